mem_stage_ctrl: RTL and testbench
=================================

# mem_stage_ctrl

Memory-stage responder sitting directly downstream of the EX/M pipeline buffer. Consumes the buffered memory-control signals (write, read, byte) together with the address and store data. Performs the access against an internal multi-cycle data RAM, stalling the pipeline until the access completes. Presents load data, registered, to the M/WB stage.

## Interface
- DEPTH, 256: number of 16-bit words in the data RAM (power of two)
- LATENCY, 2: RAM busy cycles per access (≥1)
- clk  in  1  rising-edge clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- mWrite  in  1  store request from EX/M buffer
- mRead  in  1  load request from EX/M buffer
- mByte  in  1  1 = byte access, 0 = 16-bit word access
- addr  in  16  byte address (EX/M data1 output)
- wdata  in  16  store data (EX/M op2data output)
- stall  out  1  hold EX/M buffer and upstream stages; combinational
- rdata  out  16  load result, registered
- rvalid  out  1  one-cycle pulse, rdata valid for a completed load
- misalign  out  1  one-cycle pulse, word access at odd address rejected

## Operation
- Addressing:
  - word index = addr[log2(DEPTH):1]
  - upper address bits ignored, so addresses wrap modulo 2*DEPTH bytes
  - byte lane: addr[0]=0 selects bits [7:0]; addr[0]=1 selects bits [15:8] (little-endian)
- Byte load: rdata = {8'h00, selected byte} (zero-extended).
- Byte store: wdata[7:0] is written into the selected lane only; the other lane is unchanged.
- Word load/store: full 16 bits; addr[0] must be 0.
- req = mRead | mWrite.
- mRead and mWrite both high is treated as a store; no load is performed and rvalid stays 0.
- FSM states IDLE, BUSY, DONE; 2-bit state register plus down-counter cnt.
- IDLE:
  - req with a legal alignment: latch addr, wdata, mByte and write-enable into internal registers; cnt <= LATENCY-1; go to BUSY.
  - word access with addr[0]=1: no RAM access; misalign <= 1 for one cycle; stay in IDLE.
- BUSY:
  - cnt > 0: cnt decrements.
  - cnt == 0: the access commits at this edge (RAM written, or rdata loaded with rvalid <= 1); go to DONE.
- DONE: unconditionally return to IDLE. The request still present on the inputs this cycle is the completed one and is ignored.
- stall = (state==IDLE & req & legal alignment) | (state==BUSY). It is low in DONE, so the EX/M buffer advances at the end of DONE.
- Latched registers are used during BUSY. Input changes after acceptance have no effect.
- rvalid and misalign are forced to 0 in every cycle other than their single pulse cycle.
- rdata holds its last load value through stores, misaligned requests and idle cycles.

## Timing
- Reset values: state=IDLE, cnt=0, rdata=16'h0000, rvalid=0, misalign=0, and therefore stall=0 while inputs are idle.
- RAM contents are not reset.
- rst mid-operation (BUSY) aborts the access:
  - a store whose commit edge has not occurred does not modify RAM
  - no rvalid pulse is produced
  - the FSM is in IDLE on the cycle after reset
- Accepted request presented in cycle 0:
  - stall is high for cycles 0..LATENCY
  - RAM commit happens at the end of cycle LATENCY
  - DONE is cycle LATENCY+1, with stall=0 and rvalid=1 (loads)
- Total occupancy is LATENCY+2 cycles per access.
- Back-to-back memory ops:
  - the next request appears in the IDLE cycle after DONE and stalls immediately
  - throughput is one access per LATENCY+2 cycles
- Non-memory instructions (req=0) pass with stall=0 and zero added latency.
- Misaligned word access:
  - stall=0 in the presenting cycle
  - misalign=1 in the following cycle
  - the pipeline is not held

## Test plan
- Reset, LATENCY=2:
  - hold rst for 2 cycles with mRead=1; all outputs 0
  - release, word store 16'hBEEF to addr 16'h0010; stall high 3 cycles, low in cycle 3
  - word load from 16'h0010 gives rdata=16'hBEEF with an rvalid pulse in cycle 3
- Byte lanes:
  - word store 16'h1234 at 16'h0020, then byte store 16'hxxAB at 16'h0021
  - word load from 16'h0020 gives 16'hAB34
  - byte load from 16'h0020 gives 16'h0034
- Misalign:
  - word load at 16'h0003 gives stall=0, misalign pulse next cycle, rvalid=0, rdata unchanged
  - then a byte load at 16'h0003 succeeds normally
- Simultaneous and wrap:
  - mRead=mWrite=1, word 16'h5A5A at addr 16'h0000 is stored with no rvalid
  - with DEPTH=256, a load from addr 16'h0200 returns 16'h5A5A
- Abort:
  - start a store of 16'hFFFF to 16'h0040 (prior contents 16'h0000); assert rst in the first BUSY cycle
  - a later load returns 16'h0000, and no stall persists after reset
- Back-to-back:
  - load, load, ALU op, store sequence with LATENCY=1
  - stall pattern is 1,1,0 | 1,1,0 | 0 | 1,1,0
  - rvalid pulses in cycles 2 and 5 only

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// Memory-stage responder: runs one access against a multi-cycle data RAM,
// stalls the pipeline until the access completes and returns registered load data.
module mem_stage_ctrl #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mWrite,
  input  logic        mRead,
  input  logic        mByte,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        stall,
  output logic [15:0] rdata,
  output logic        rvalid,
  output logic        misalign
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CntInit = CW'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] idx_q;
  logic          lane_q;
  logic          byte_q;
  logic          we_q;
  logic [15:0]   wdata_q;

  logic [15:0]   mem [DEPTH];

  logic          req;
  logic          legal;
  logic          commit;
  logic [15:0]   rd_word;
  logic [15:0]   load_val;
  logic          unused_addr_hi;

  assign req    = mRead | mWrite;
  assign legal  = mByte | ~addr[0];
  assign commit = (state_q == StBusy) && (cnt_q == '0);

  // Reset overrides the request so nothing upstream is held while in reset.
  assign stall = ~rst & (((state_q == StIdle) & req & legal) | (state_q == StBusy));

  assign rd_word  = mem[idx_q];
  assign load_val = byte_q ? {8'h00, (lane_q ? rd_word[15:8] : rd_word[7:0])} : rd_word;

  // Upper address bits are deliberately ignored: addresses wrap modulo 2*DEPTH.
  assign unused_addr_hi = ^addr[15:AW+1];

  // RAM contents are not reset; a reset before the commit edge aborts the store.
  always_ff @(posedge clk) begin
    if (!rst && commit && we_q) begin
      if (!byte_q) begin
        mem[idx_q] <= wdata_q;
      end else if (lane_q) begin
        mem[idx_q][15:8] <= wdata_q[7:0];
      end else begin
        mem[idx_q][7:0] <= wdata_q[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      lane_q   <= 1'b0;
      byte_q   <= 1'b0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata    <= '0;
      rvalid   <= 1'b0;
      misalign <= 1'b0;
    end else begin
      rvalid   <= 1'b0;
      misalign <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            if (legal) begin
              idx_q   <= addr[AW:1];
              lane_q  <= addr[0];
              byte_q  <= mByte;
              we_q    <= mWrite;
              wdata_q <= wdata;
              cnt_q   <= CntInit;
              state_q <= StBusy;
            end else begin
              misalign <= 1'b1;
            end
          end
        end
        StBusy: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            // Read-and-write together is a store, so no load result is produced.
            if (!we_q) begin
              rdata  <= load_val;
              rvalid <= 1'b1;
            end
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios plus randomized
// accesses compared against a word-array memory model.
module tb_mem_stage_ctrl;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned L     = 2;

  logic        clk;
  logic        rst;
  logic        mw, mr, mb;
  logic [15:0] ad, wd;
  logic        stall, rvalid, misalign;
  logic [15:0] rdata;

  logic        mw1, mr1, mb1;
  logic [15:0] ad1, wd1;
  logic        stall1, rvalid1, misalign1;
  logic [15:0] rdata1;

  int checks = 0;
  int errors = 0;

  logic [15:0] mdl [DEPTH];
  logic [15:0] exp_rdata;

  int seq      [10] = '{1, 1, 1, 1, 1, 1, 0, 2, 2, 2};
  int exp_st1  [10] = '{1, 1, 0, 1, 1, 0, 0, 1, 1, 0};
  int exp_rv1  [10] = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 0};

  mem_stage_ctrl #(.DEPTH(DEPTH), .LATENCY(L)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .mWrite   (mw),
    .mRead    (mr),
    .mByte    (mb),
    .addr     (ad),
    .wdata    (wd),
    .stall    (stall),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .misalign (misalign)
  );

  mem_stage_ctrl #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .mWrite   (mw1),
    .mRead    (mr1),
    .mByte    (mb1),
    .addr     (ad1),
    .wdata    (wd1),
    .stall    (stall1),
    .rdata    (rdata1),
    .rvalid   (rvalid1),
    .misalign (misalign1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    mw = 1'b0; mr = 1'b0; mb = 1'b0; ad = 16'h0000; wd = 16'h0000;
  endtask

  // One instruction through the memory stage; expectations come from the model.
  task automatic do_op(input logic w, input logic r, input logic b,
                       input logic [15:0] a, input logic [15:0] d);
    int          idx;
    bit          is_load;
    logic [15:0] exp_load;
    idx = (int'(a) / 2) % int'(DEPTH);
    mw = w; mr = r; mb = b; ad = a; wd = d;
    if (!(w || r)) begin
      @(negedge clk);
      chk("alu_stall", 16'(stall), 16'h0);
      chk("alu_rvalid", 16'(rvalid), 16'h0);
      chk("alu_misalign", 16'(misalign), 16'h0);
      @(posedge clk); #1;
    end else if (!b && a[0]) begin
      @(negedge clk);
      chk("mis_stall0", 16'(stall), 16'h0);
      chk("mis_pulse0", 16'(misalign), 16'h0);
      @(posedge clk); #1;
      set_idle();
      @(negedge clk);
      chk("mis_pulse1", 16'(misalign), 16'h1);
      chk("mis_stall1", 16'(stall), 16'h0);
      chk("mis_rvalid", 16'(rvalid), 16'h0);
      chk("mis_rdata", rdata, exp_rdata);
      @(posedge clk); #1;
    end else begin
      is_load = r && !w;
      if (!b)        exp_load = mdl[idx];
      else if (a[0]) exp_load = {8'h00, mdl[idx][15:8]};
      else           exp_load = {8'h00, mdl[idx][7:0]};
      for (int k = 0; k <= int'(L) + 1; k++) begin
        @(negedge clk);
        chk("acc_stall", 16'(stall), 16'(k <= int'(L)));
        chk("acc_rvalid", 16'(rvalid), 16'((k == int'(L) + 1) && is_load));
        chk("acc_misalign", 16'(misalign), 16'h0);
        if (k == int'(L) + 1) begin
          if (is_load) exp_rdata = exp_load;
          chk("acc_rdata", rdata, exp_rdata);
        end
        @(posedge clk); #1;
      end
      if (w) begin
        if (!b)        mdl[idx] = d;
        else if (a[0]) mdl[idx][15:8] = d[7:0];
        else           mdl[idx][7:0] = d[7:0];
      end
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    mw1 = 1'b0; mr1 = 1'b0; mb1 = 1'b0; ad1 = 16'h0000; wd1 = 16'h0000;
    exp_rdata = 16'h0000;

    // Reset held two cycles with a load pending.
    rst = 1'b1;
    mr  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_stall", 16'(stall), 16'h0);
      chk("rst_rdata", rdata, 16'h0000);
      chk("rst_rvalid", 16'(rvalid), 16'h0);
      chk("rst_misalign", 16'(misalign), 16'h0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    set_idle();

    do_op(1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF);
    do_op(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    chk("beef_load", rdata, 16'hBEEF);

    // Byte lanes
    do_op(1'b1, 1'b0, 1'b0, 16'h0020, 16'h1234);
    do_op(1'b1, 1'b0, 1'b1, 16'h0021, 16'hCDAB);
    do_op(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
    chk("lane_word", rdata, 16'hAB34);
    do_op(1'b0, 1'b1, 1'b1, 16'h0020, 16'h0000);
    chk("lane_byte", rdata, 16'h0034);

    // Misalign, then a legal byte load at the same odd address
    do_op(1'b1, 1'b0, 1'b0, 16'h0002, 16'h7788);
    do_op(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000);
    chk("mis_keep", rdata, 16'h0034);
    do_op(1'b0, 1'b1, 1'b1, 16'h0003, 16'h0000);
    chk("odd_byte", rdata, 16'h0077);

    // Simultaneous read+write is a store; address wraps modulo 512 bytes
    do_op(1'b1, 1'b1, 1'b0, 16'h0000, 16'h5A5A);
    do_op(1'b0, 1'b1, 1'b0, 16'h0200, 16'h0000);
    chk("wrap_load", rdata, 16'h5A5A);

    // Abort a store with reset in the first busy cycle
    do_op(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000);
    mw = 1'b1; ad = 16'h0040; wd = 16'hFFFF;
    @(negedge clk);
    chk("abort_stall0", 16'(stall), 16'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    set_idle();
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rdata = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_stall", 16'(stall), 16'h0);
      chk("abort_rvalid", 16'(rvalid), 16'h0);
      chk("abort_rdata", rdata, 16'h0000);
      @(posedge clk); #1;
    end
    do_op(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000);
    chk("abort_load", rdata, 16'h0000);
    do_op(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // Back-to-back with LATENCY=1: load, load, ALU, store
    for (int c = 0; c < 10; c++) begin
      mr1 = (seq[c] == 1);
      mw1 = (seq[c] == 2);
      ad1 = 16'h0004;
      wd1 = 16'h1111;
      @(negedge clk);
      chk("b2b_stall", 16'(stall1), 16'(exp_st1[c]));
      chk("b2b_rvalid", 16'(rvalid1), 16'(exp_rv1[c]));
      @(posedge clk); #1;
    end
    mr1 = 1'b0; mw1 = 1'b0;

    // Randomized accesses over a pre-initialized window with random upper bits
    for (int i = 0; i < 16; i++) begin
      do_op(1'b1, 1'b0, 1'b0, 16'($urandom & 32'hFE00) | 16'(i * 2), 16'($urandom));
    end
    for (int i = 0; i < 40; i++) begin
      do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            16'($urandom & 32'hFE1F), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
